// File: rtl/fpu_req_issuer_pkg.sv
// Shared definitions for the div/sqrt issue stage.
//   OP_DIV / OP_SQRT : request opcode and FPU process select values
//   QNAN             : result word reported when an operation is aborted
//   state_e          : issue FSM encoding
package fpu_req_issuer_pkg;

  localparam logic        OP_DIV  = 1'b0;
  localparam logic        OP_SQRT = 1'b1;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_Z = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_req_issuer_if.sv
// Request/response port of the div/sqrt issue stage.
//   req_valid/req_ready : request handshake, transfer on valid&ready
//   req_op/a/b/tag      : opcode (0=div, 1=sqrt), operands, caller tag
//   rsp_valid/rsp_ready : response handshake, pop on valid&ready
//   rsp_z/tag/err       : result, returned tag, watchdog-abort flag
// master = requester side, slave = issuer side.
interface fpu_req_issuer_if #(
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_z;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_tag, rsp_err
  );

endinterface

// File: rtl/fpu_rsp_fifo.sv
// Synchronous show-ahead FIFO holding issue-stage responses.
//   clk, rst   : clock, synchronous active-high reset
//   push/data  : write port (ignored when full)
//   pop        : read port (ignored when empty); pop_data shows the head
//   count      : number of stored entries (0..DEPTH)
//   full/empty : status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_rsp_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == {CNT_W{1'b0}});
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage array: cleared on reset so the head never shows stale data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Read/write pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fpu_req_issuer.sv
// Issue stage for the single-precision div/sqrt unit.
//   clk, rst        : clock, synchronous active-high reset
//   rq (slave)      : request/response port, see fpu_req_issuer_if
//   input_a/b       : operands to the FPU, with input_a_stb/input_b_stb
//   input_a/b_ack   : operand acknowledges from the FPU
//   process         : FPU operation select, 0=div, 1=sqrt
//   output_z(_stb)  : FPU result and strobe; output_z_ack acknowledges it
//   err_timeout     : sticky flag, set when the watchdog aborts an operation
// One operation is in flight at a time; results land in a small FIFO.
module fpu_req_issuer
  import fpu_req_issuer_pkg::*;
#(
  parameter int RSP_DEPTH   = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  fpu_req_issuer_if.slave rq,
  output logic [31:0] input_a,
  output logic [31:0] input_b,
  output logic        input_a_stb,
  output logic        input_b_stb,
  output logic        process,
  input  logic        input_a_ack,
  input  logic        input_b_ack,
  input  logic [31:0] output_z,
  input  logic        output_z_stb,
  output logic        output_z_ack,
  output logic        err_timeout
);

  localparam int         FIFO_W  = 32 + TAG_W + 1;
  localparam int         CNT_W   = $clog2(RSP_DEPTH) + 1;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  state_e             state_r;
  state_e             state_s;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [TAG_W-1:0]   tag_r;
  logic               process_r;
  logic               a_stb_r;
  logic               b_stb_r;
  logic [7:0]         wd_r;
  logic               z_ack_r;
  logic [31:0]        z_r;
  logic               err_timeout_r;

  logic               req_ready_s;
  logic               accept_s;
  logic               busy_s;
  logic               timeout_s;
  logic               done_s;
  logic               abort_s;
  logic               z_take_s;
  logic               a_pend_s;
  logic               b_pend_s;
  logic               push_s;
  logic [FIFO_W-1:0]  push_data_s;
  logic [FIFO_W-1:0]  pop_data_s;
  logic               pop_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  // Handshake and control decode shared by the FSM and the datapath
  always_comb begin
    req_ready_s = (state_r == IDLE) && (fifo_count_s < CNT_W'(RSP_DEPTH));
    accept_s    = rq.req_valid && req_ready_s;
    busy_s      = (state_r == ISSUE) || (state_r == WAIT_Z);
    // wd_r counts completed busy cycles, so this is the last allowed one
    timeout_s   = busy_s && (wd_r == WD_LAST);
    // The ack cycle is the completion point; it wins over a timeout there
    done_s      = (state_r == WAIT_Z) && z_ack_r;
    abort_s     = timeout_s && !done_s;
    // A strobe during the ack cycle is the same result still being held
    z_take_s    = (state_r == WAIT_Z) && !z_ack_r && output_z_stb && !timeout_s;
    a_pend_s    = a_stb_r && !input_a_ack;
    b_pend_s    = b_stb_r && !input_b_ack;
    push_s      = (done_s || abort_s) && !fifo_full_s;
    pop_s       = rq.rsp_ready && !fifo_empty_s;
  end

  // Response word: normal result or the abort marker
  always_comb begin
    push_data_s = {z_r, tag_r, 1'b0};
    if (abort_s) begin
      push_data_s = {QNAN, tag_r, 1'b1};
    end else begin
      push_data_s = {z_r, tag_r, 1'b0};
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (abort_s) begin
          state_s = IDLE;
        end else if (!a_pend_s && !b_pend_s) begin
          state_s = WAIT_Z;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_Z: begin
        if (done_s || abort_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_Z;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, tag and process select capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= 32'h0000_0000;
      b_r       <= 32'h0000_0000;
      tag_r     <= {TAG_W{1'b0}};
      process_r <= OP_DIV;
    end else if (accept_s) begin
      a_r       <= rq.req_a;
      b_r       <= rq.req_b;
      tag_r     <= rq.req_tag;
      process_r <= rq.req_op;
    end else begin
      a_r       <= a_r;
      b_r       <= b_r;
      tag_r     <= tag_r;
      process_r <= process_r;
    end
  end

  // Operand strobes: each drops independently once its own ack is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      a_stb_r <= 1'b0;
      b_stb_r <= 1'b0;
    end else if (accept_s) begin
      a_stb_r <= 1'b1;
      b_stb_r <= (rq.req_op == OP_DIV);
    end else if (abort_s) begin
      a_stb_r <= 1'b0;
      b_stb_r <= 1'b0;
    end else begin
      a_stb_r <= a_pend_s;
      b_stb_r <= b_pend_s;
    end
  end

  // Watchdog: counts cycles spent in ISSUE and WAIT_Z
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= 8'd0;
    end else if (accept_s) begin
      wd_r <= 8'd0;
    end else if (busy_s) begin
      wd_r <= wd_r + 8'd1;
    end else begin
      wd_r <= wd_r;
    end
  end

  // Result capture and one-cycle output_z_ack
  always_ff @(posedge clk) begin
    if (rst) begin
      z_ack_r <= 1'b0;
      z_r     <= 32'h0000_0000;
    end else begin
      z_ack_r <= z_take_s;
      if (z_take_s) begin
        z_r <= output_z;
      end else begin
        z_r <= z_r;
      end
    end
  end

  // Sticky abort flag, only cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout_r <= 1'b0;
    end else if (abort_s) begin
      err_timeout_r <= 1'b1;
    end else begin
      err_timeout_r <= err_timeout_r;
    end
  end

  fpu_rsp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign rq.req_ready = req_ready_s;
  assign rq.rsp_valid = !fifo_empty_s;
  assign {rq.rsp_z, rq.rsp_tag, rq.rsp_err} = pop_data_s;

  assign input_a      = a_r;
  assign input_b      = b_r;
  assign input_a_stb  = a_stb_r;
  assign input_b_stb  = b_stb_r;
  assign process      = process_r;
  assign output_z_ack = z_ack_r;
  assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_fpu_req_issuer.sv
// Directed bench for fpu_req_issuer with a behavioural FPU model
// (programmable ack/result delays) and a response scoreboard queue.
module tb_fpu_req_issuer;
  import fpu_req_issuer_pkg::*;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      z;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_req_issuer_if #(.TAG_W(TAG_W)) rq ();

  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_b_stb, process;
  logic        input_a_ack, input_b_ack, output_z_stb, output_z_ack, err_timeout;

  fpu_req_issuer #(.RSP_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYC(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .rq           (rq),
    .input_a      (input_a),
    .input_b      (input_b),
    .input_a_stb  (input_a_stb),
    .input_b_stb  (input_b_stb),
    .process      (process),
    .input_a_ack  (input_a_ack),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .err_timeout  (err_timeout)
  );

  // ---------------- behavioural FPU model ----------------
  int   a_dly = 0, b_dly = 0, z_dly = 0;
  logic z_never = 1'b0, z_inj = 1'b0;
  logic a_ack_m, b_ack_m, z_stb_m, got_a, got_b, proc_lat;
  logic [31:0] a_lat, b_lat, z_val;
  int   a_cnt, b_cnt, z_cnt;

  function automatic logic [31:0] fpu_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, b};
    if (op == OP_SQRT) begin
      case (a)
        32'h4180_0000: return 32'h4080_0000;
        32'h4080_0000: return 32'h4000_0000;
        32'h4110_0000: return 32'h4040_0000;
        32'h3F80_0000: return 32'h3F80_0000;
        default:       return a ^ 32'h0F0F_0F0F;
      endcase
    end else begin
      case (ab)
        64'h40C0_0000_4000_0000: return 32'h4040_0000;
        64'h4100_0000_4000_0000: return 32'h4080_0000;
        64'h4110_0000_4040_0000: return 32'h4040_0000;
        64'h3F80_0000_4000_0000: return 32'h3F00_0000;
        default:                 return a ^ b;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      a_ack_m <= 1'b0; b_ack_m <= 1'b0; z_stb_m <= 1'b0;
      got_a <= 1'b0; got_b <= 1'b0; proc_lat <= 1'b0;
      a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
      a_lat <= 32'h0; b_lat <= 32'h0; z_val <= 32'h0;
    end else begin
      if (a_ack_m) begin
        a_ack_m <= 1'b0; a_cnt <= 0; got_a <= 1'b1; a_lat <= input_a; proc_lat <= process;
      end else if (input_a_stb) begin
        if (a_cnt >= a_dly) a_ack_m <= 1'b1; else a_cnt <= a_cnt + 1;
      end
      if (b_ack_m) begin
        b_ack_m <= 1'b0; b_cnt <= 0; got_b <= 1'b1; b_lat <= input_b;
      end else if (input_b_stb) begin
        if (b_cnt >= b_dly) b_ack_m <= 1'b1; else b_cnt <= b_cnt + 1;
      end
      if (z_stb_m) begin
        if (output_z_ack) begin
          z_stb_m <= 1'b0; got_a <= 1'b0; got_b <= 1'b0; z_cnt <= 0;
        end
      end else if (got_a && (got_b || proc_lat == OP_SQRT) && !z_never) begin
        if (z_cnt >= z_dly) begin
          z_stb_m <= 1'b1; z_val <= fpu_fn(proc_lat, a_lat, b_lat);
        end else begin
          z_cnt <= z_cnt + 1;
        end
      end
    end
  end

  assign input_a_ack  = a_ack_m;
  assign input_b_ack  = b_ack_m;
  assign output_z     = z_val;
  assign output_z_stb = z_stb_m | z_inj;

  // ---------------- monitor ----------------
  int   cyc = 0, b_stb_cnt = 0, z_ack_cnt = 0;
  int   a_fall_cyc = 0, b_fall_cyc = 0, a_rise_cyc = 0, z_ack_cyc = 0;
  logic prev_a = 1'b0, prev_b = 1'b0, last_proc = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (input_b_stb) b_stb_cnt <= b_stb_cnt + 1;
    if (input_a_stb) last_proc <= process;
    if (output_z_ack) begin
      z_ack_cnt <= z_ack_cnt + 1;
      z_ack_cyc <= cyc;
    end
    if (prev_a && !input_a_stb) a_fall_cyc <= cyc;
    if (prev_b && !input_b_stb) b_fall_cyc <= cyc;
    if (!prev_a && input_a_stb) a_rise_cyc <= cyc;
    prev_a <= input_a_stb;
    prev_b <= input_b_stb;
  end

  // ---------------- checking helpers ----------------
  int   checks = 0, failures = 0;
  rsp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] expz, input logic experr);
    int   n;
    rsp_t e;
    n = 0;
    rq.req_op = op; rq.req_a = a; rq.req_b = b; rq.req_tag = tag; rq.req_valid = 1'b1;
    while (!rq.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept_bound", 64'(n < 500), 64'd1);
    @(negedge clk);
    rq.req_valid = 1'b0;
    e.z = expz; e.tag = tag; e.err = experr;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int   n;
    rsp_t e;
    n = 0;
    while (!rq.rsp_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_rsp_bound"}, 64'(n < 600), 64'd1);
    if (exp_q.size() == 0) begin
      chk({name, "_scoreboard_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_z"},   64'(rq.rsp_z),   64'(e.z));
      chk({name, "_tag"}, 64'(rq.rsp_tag), 64'(e.tag));
      chk({name, "_err"}, 64'(rq.rsp_err), 64'(e.err));
    end
    rq.rsp_ready = 1'b1;
    @(negedge clk);
    rq.rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, base2, n;
    rst = 1'b1;
    rq.req_valid = 1'b0; rq.req_op = 1'b0; rq.req_a = 32'h0; rq.req_b = 32'h0;
    rq.req_tag = '0; rq.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_a_stb", 64'(input_a_stb), 64'd0);
    chk("rst_b_stb", 64'(input_b_stb), 64'd0);
    chk("rst_z_ack", 64'(output_z_ack), 64'd0);
    chk("rst_process", 64'(process), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    chk("rst_rsp_valid", 64'(rq.rsp_valid), 64'd0);
    chk("rst_input_a", 64'(input_a), 64'd0);
    chk("rst_req_ready", 64'(rq.req_ready), 64'd1);

    // 1: divide 6.0 / 2.0
    a_dly = 1; b_dly = 1; z_dly = 2;
    base = b_stb_cnt;
    send(OP_DIV, 32'h40C0_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 1'b0);
    drain("div6_2");
    chk("div_b_stb_seen", 64'(b_stb_cnt > base), 64'd1);
    chk("div_process", 64'(last_proc), 64'(OP_DIV));

    // 2: sqrt 16.0
    base = b_stb_cnt;
    send(OP_SQRT, 32'h4180_0000, 32'h0, 4'd5, 32'h4080_0000, 1'b0);
    drain("sqrt16");
    chk("sqrt_b_stb_never", 64'(b_stb_cnt - base), 64'd0);
    chk("sqrt_process", 64'(last_proc), 64'(OP_SQRT));

    // 3: b ack three cycles ahead of a ack
    a_dly = 4; b_dly = 1; z_dly = 1;
    base = z_ack_cnt;
    send(OP_DIV, 32'h4100_0000, 32'h4000_0000, 4'd7, 32'h4080_0000, 1'b0);
    drain("div8_2");
    repeat (2) @(negedge clk);
    chk("b_stb_drops_first", 64'(a_fall_cyc - b_fall_cyc), 64'd3);
    chk("single_z_ack", 64'(z_ack_cnt - base), 64'd1);

    // 4: fill the FIFO with rsp_ready low, fifth request held off
    a_dly = 0; b_dly = 0; z_dly = 0;
    send(OP_SQRT, 32'h4080_0000, 32'h0,          4'd1, 32'h4000_0000, 1'b0);
    send(OP_SQRT, 32'h4110_0000, 32'h0,          4'd2, 32'h4040_0000, 1'b0);
    @(negedge clk);
    chk("back_to_back_stb", 64'(a_rise_cyc - z_ack_cyc), 64'd2);
    send(OP_DIV,  32'h4110_0000, 32'h4040_0000, 4'd4, 32'h4040_0000, 1'b0);
    send(OP_DIV,  32'h3F80_0000, 32'h4000_0000, 4'd8, 32'h3F00_0000, 1'b0);
    repeat (30) @(negedge clk);
    rq.req_op = OP_SQRT; rq.req_a = 32'h3F80_0000; rq.req_b = 32'h0; rq.req_tag = 4'd12;
    rq.req_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("full_req_ready_low", 64'(rq.req_ready), 64'd0);
    chk("full_no_issue", 64'(input_a_stb), 64'd0);
    drain("fill_1");
    n = 0;
    while (!rq.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_accept_bound", 64'(n < 50), 64'd1);
    @(negedge clk);
    rq.req_valid = 1'b0;
    exp_q.push_back('{z: 32'h3F80_0000, tag: 4'd12, err: 1'b0});
    drain("fill_2");
    drain("fill_3");
    drain("fill_4");
    drain("fill_5");

    // 5: result never arrives -> watchdog abort
    a_dly = 1; b_dly = 1; z_never = 1'b1;
    send(OP_DIV, 32'h40C0_0000, 32'h4000_0000, 4'd9, QNAN, 1'b1);
    n = 0;
    while (!rq.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("watchdog_cycles", 64'(n), 64'd255);
    chk("abort_stbs_low", 64'({input_a_stb, input_b_stb}), 64'd0);
    drain("timeout");
    repeat (3) @(negedge clk);
    chk("err_timeout_sticky", 64'(err_timeout), 64'd1);

    // z strobe while idle is ignored
    base2 = z_ack_cnt;
    z_inj = 1'b1;
    repeat (3) @(negedge clk);
    z_inj = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_z_no_ack", 64'(z_ack_cnt - base2), 64'd0);
    chk("idle_z_no_push", 64'(rq.rsp_valid), 64'd0);

    // 6: reset while waiting for a result
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    z_never = 1'b0; z_dly = 30; a_dly = 1; b_dly = 1;
    @(negedge clk);
    chk("rst_clears_err_timeout", 64'(err_timeout), 64'd0);
    send(OP_SQRT, 32'h4080_0000, 32'h0, 4'd6, 32'h4000_0000, 1'b0);
    repeat (10) @(negedge clk);
    chk("wait_z_busy", 64'({rq.req_ready, input_a_stb, rq.rsp_valid}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_rst_stbs", 64'({input_a_stb, input_b_stb}), 64'd0);
    chk("midop_rst_rsp_valid", 64'(rq.rsp_valid), 64'd0);
    chk("midop_rst_req_ready", 64'(rq.req_ready), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    z_dly = 2;
    @(negedge clk);
    send(OP_DIV, 32'h4110_0000, 32'h4040_0000, 4'd2, 32'h4040_0000, 1'b0);
    drain("after_rst");
    repeat (3) @(negedge clk);
    chk("no_stale_rsp", 64'(rq.rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
